// File: rtl/alu_seq_param.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic, iterative shifts and,
// when ALU_SEQ_MUL_EN is defined, an iterative shift-add multiply.
module alu_seq_param #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [SH_W-1:0] STEP = SH_W'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, MUL = 2'b10} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [SH_W-1:0]  cnt, cnt_nx;
  logic [3:0]       op, op_nx;
  logic             busy_nx, done_nx;
  logic             upd;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mplr, mplr_nx;
  logic [WIDTH-1:0] acc, acc_nx, acc_sum;
`endif

  logic             sub;
  logic [WIDTH-1:0] bop;
  logic [WIDTH:0]   sum_ext;
  logic             ovf;
  logic [SH_W-1:0]  amt;
  logic [WIDTH-1:0] shifted;

  // Shared adder for ADD/SUB/SLT/SLTU; V = (A^S) & ~(A^B^sub) at the MSB
  always_comb begin
    sub     = (sel == OP_SUB) || (sel == OP_SLT) || (sel == OP_SLTU);
    bop     = sub ? ~B : B;
    sum_ext = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
    ovf     = (A[WIDTH-1] ^ sum_ext[WIDTH-1]) & ~(A[WIDTH-1] ^ B[WIDTH-1] ^ sub);
  end

  // One shift step of at most STEP bits on the latched operand
  always_comb begin
    amt = (cnt < STEP) ? cnt : STEP;
    case (op)
      OP_SLL:  shifted = work << amt;
      OP_SRA:  shifted = WIDTH'($signed(work) >>> amt);
      default: shifted = work >> amt;
    endcase
  end

  // Next-state and completion logic
  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    op_nx    = op;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    upd      = 1'b0;
    res      = {WIDTH{1'b0}};
    res_c    = 1'b0;
    res_v    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mplr_nx  = mplr;
    acc_nx   = acc;
    acc_sum  = acc + (mplr[0] ? work : {WIDTH{1'b0}});
`endif
    case (state)
      IDLE: begin
        if (start) begin
          upd = 1'b1;
          case (sel)
            OP_ADD, OP_SUB: begin
              res   = sum_ext[WIDTH-1:0];
              res_c = sum_ext[WIDTH];
              res_v = ovf;
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_SLT: begin
              res   = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ ovf};
              res_c = sum_ext[WIDTH];
              res_v = ovf;
            end
            OP_SLTU: begin
              res   = {{(WIDTH-1){1'b0}}, ~sum_ext[WIDTH]};
              res_c = sum_ext[WIDTH];
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              if (B[SH_W-1:0] == {SH_W{1'b0}}) begin
                res = A;
              end else begin
                upd      = 1'b0;
                state_nx = SHIFT;
                work_nx  = A;
                cnt_nx   = B[SH_W-1:0];
                op_nx    = sel;
                busy_nx  = 1'b1;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              upd      = 1'b0;
              state_nx = MUL;
              work_nx  = A;
              mplr_nx  = B;
              acc_nx   = {WIDTH{1'b0}};
              cnt_nx   = {SH_W{1'b0}};
              busy_nx  = 1'b1;
            end
`endif
            default: res = {WIDTH{1'b0}};
          endcase
          done_nx = upd;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        work_nx = shifted;
        cnt_nx  = cnt - amt;
        if (cnt <= STEP) begin
          upd      = 1'b1;
          res      = shifted;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          busy_nx = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        acc_nx  = acc_sum;
        work_nx = work << 1;
        mplr_nx = mplr >> 1;
        cnt_nx  = cnt + SH_W'(1);
        if (cnt == SH_W'(WIDTH - 1)) begin
          upd      = 1'b1;
          res      = acc_sum;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          busy_nx = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered outputs; result/flags load only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= {WIDTH{1'b0}};
      cnt      <= {SH_W{1'b0}};
      op       <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      ALUOut   <= {WIDTH{1'b0}};
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mplr     <= {WIDTH{1'b0}};
      acc      <= {WIDTH{1'b0}};
`endif
    end else begin
      state <= state_nx;
      work  <= work_nx;
      cnt   <= cnt_nx;
      op    <= op_nx;
      busy  <= busy_nx;
      done  <= done_nx;
`ifdef ALU_SEQ_MUL_EN
      mplr  <= mplr_nx;
      acc   <= acc_nx;
`endif
      if (upd) begin
        ALUOut   <= res;
        Zero     <= (res == {WIDTH{1'b0}});
        Negative <= res[WIDTH-1];
        Carry    <= res_c;
        Overflow <= res_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed table, randomized ops against a
// reference model, back-to-back starts and async reset mid-operation.
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] a_in = 32'h0;
  logic [31:0] b_in = 32'h0;

  logic        busy1, done1, z1, n1, c1, v1;
  logic [31:0] out1;
  logic        busy4, done4, z4, n4, c4, v4;
  logic [31:0] out4;

  int total = 0;
  int bad = 0;
  logic [31:0] prev1 = 32'h0;
  logic [31:0] prev4 = 32'h0;

  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .A(a_in), .B(b_in),
    .busy(busy1), .done(done1), .ALUOut(out1), .Zero(z1), .Negative(n1),
    .Carry(c1), .Overflow(v1));

  alu_seq_param #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .A(a_in), .B(b_in),
    .busy(busy4), .done(done4), .ALUOut(out4), .Zero(z4), .Negative(n4),
    .Carry(c4), .Overflow(v4));

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;   // {Z,N,C,V}
    int          l1;
    int          l4;
  } vec_t;

  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -64'sh8000_0000;

  function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, r;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    e.res = 32'h0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (s)
      4'h0: begin
        r = sa + sb;
        e.res = a + b;
        e.c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        e.v = (r > MAXS) || (r < MINS);
      end
      4'h1: begin
        r = sa - sb;
        e.res = a - b;
        e.c = (a >= b);
        e.v = (r > MAXS) || (r < MINS);
      end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: begin
        r = sa - sb;
        e.res = {31'h0, sa < sb};
        e.c = (a >= b);
        e.v = (r > MAXS) || (r < MINS);
      end
      4'h6: begin
        e.res = {31'h0, a < b};
        e.c = (a >= b);
      end
      4'h7: e.res = a << sh;
      4'h8: e.res = a >> sh;
      4'h9: e.res = $signed(a) >>> sh;
`ifdef ALU_SEQ_MUL_EN
      4'hA: e.res = a * b;
`endif
      default: e.res = 32'h0;
    endcase
    return e;
  endfunction

  function automatic int lat_of(input logic [3:0] s, input logic [31:0] b, input int step);
    int sh;
    sh = int'(b[4:0]);
    if (s == 4'h7 || s == 4'h8 || s == 4'h9) return (sh + step - 1) / step;
`ifdef ALU_SEQ_MUL_EN
    if (s == 4'hA) return 32;
`endif
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_one(input string nm, input int k, input int lat,
                           input logic b, input logic d, input logic [31:0] o,
                           input logic [3:0] fl, input logic [31:0] eo,
                           input logic [3:0] ef, input logic [31:0] prev);
    if (k <= lat) begin
      chk({nm, " busy"}, 64'(b), 64'h1);
      chk({nm, " done"}, 64'(d), 64'h0);
      chk({nm, " held"}, 64'(o), 64'(prev));
    end else if (k == lat + 1) begin
      chk({nm, " busy"}, 64'(b), 64'h0);
      chk({nm, " done"}, 64'(d), 64'h1);
      chk({nm, " out"}, 64'(o), 64'(eo));
      chk({nm, " flags"}, 64'(fl), 64'(ef));
    end else begin
      chk({nm, " busy"}, 64'(b), 64'h0);
      chk({nm, " done"}, 64'(d), 64'h0);
      chk({nm, " out"}, 64'(o), 64'(eo));
    end
  endtask

  // Entered at a falling edge; returns at a falling edge with start low.
  task automatic run_op(input string nm, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input logic [3:0] ef,
                        input int l1, input int l4);
    int maxl, minl;
    maxl = (l1 > l4) ? l1 : l4;
    minl = (l1 < l4) ? l1 : l4;
    start = 1'b1;
    sel = s;
    a_in = a;
    b_in = b;
    for (int k = 1; k <= maxl + 1; k++) begin
      @(negedge clk);
      check_one({nm, " s1"}, k, l1, busy1, done1, out1, {z1, n1, c1, v1}, eo, ef, prev1);
      check_one({nm, " s4"}, k, l4, busy4, done4, out4, {z4, n4, c4, v4}, eo, ef, prev4);
      if (k <= minl) begin
        start = 1'($urandom_range(0, 1));
        sel = 4'($urandom);
        a_in = $urandom;
        b_in = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    prev1 = eo;
    prev4 = eo;
  endtask

  vec_t tv[15];

  initial begin
    exp_t        e;
    logic [3:0]  s;
    logic [31:0] a, b;

    tv[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0101, 0, 0};
    tv[1]  = '{4'h1, 32'h5, 32'h5, 32'h0, 4'b1010, 0, 0};
    tv[2]  = '{4'h1, 32'h0, 32'h1, 32'hFFFF_FFFF, 4'b0100, 0, 0};
    tv[3]  = '{4'h5, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0010, 0, 0};
    tv[4]  = '{4'h6, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1010, 0, 0};
    tv[5]  = '{4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 0, 0};
    tv[6]  = '{4'h3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000, 0, 0};
    tv[7]  = '{4'h4, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b0100, 0, 0};
    tv[8]  = '{4'h9, 32'h8000_0000, 32'h4, 32'hF800_0000, 4'b0100, 4, 1};
    tv[9]  = '{4'h7, 32'h1, 32'd31, 32'h8000_0000, 4'b0100, 31, 8};
    tv[10] = '{4'h8, 32'h8000_0000, 32'h21, 32'h4000_0000, 4'b0000, 1, 1};
    tv[11] = '{4'h7, 32'h0000_ABCD, 32'h20, 32'h0000_ABCD, 4'b0000, 0, 0};
    tv[12] = '{4'hF, 32'h5, 32'h7, 32'h0, 4'b1000, 0, 0};
`ifdef ALU_SEQ_MUL_EN
    tv[13] = '{4'hA, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 4'b0100, 32, 32};
`else
    tv[13] = '{4'hA, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 4'b1000, 0, 0};
`endif
    tv[14] = '{4'h8, 32'hFFFF_FFFF, 32'h7, 32'h01FF_FFFF, 4'b0000, 7, 2};

    #3;
    chk("reset s1", {26'h0, busy1, done1, out1, z1, n1, c1, v1}, 64'h0);
    chk("reset s4", {26'h0, busy4, done4, out4, z4, n4, c4, v4}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), tv[i].sel, tv[i].a, tv[i].b, tv[i].res, tv[i].fl,
             tv[i].l1, tv[i].l4);

    for (int i = 0; i < 150; i++) begin
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      e = model(s, a, b);
      run_op($sformatf("rnd%0d", i), s, a, b, e.res,
             {e.res == 32'h0, e.res[31], e.c, e.v}, lat_of(s, b, 1), lat_of(s, b, 4));
    end

    // Four back-to-back single-cycle starts: one done and result per cycle
    start = 1'b1;
    sel = 4'h0;
    a_in = 32'h1111_1111;
    b_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = model(4'h0, 32'h1111_1111 * 32'(i + 1), 32'(i));
      chk($sformatf("b2b%0d s1 done", i), 64'(done1), 64'h1);
      chk($sformatf("b2b%0d s1 out", i), 64'(out1), 64'(e.res));
      chk($sformatf("b2b%0d s4 done", i), 64'(done4), 64'h1);
      chk($sformatf("b2b%0d s4 out", i), 64'(out4), 64'(e.res));
      prev1 = e.res;
      prev4 = e.res;
      if (i < 3) begin
        a_in = 32'h1111_1111 * 32'(i + 2);
        b_in = 32'(i + 1);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b end s1 done", 64'(done1), 64'h0);
    chk("b2b end s4 done", 64'(done4), 64'h0);

    // Async reset in the middle of a long SRL
    start = 1'b1;
    sel = 4'h8;
    a_in = 32'hFFFF_FFFF;
    b_in = 32'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-rst s1 busy", 64'(busy1), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst s1", {26'h0, busy1, done1, out1, z1, n1, c1, v1}, 64'h0);
    chk("midrst s4", {26'h0, busy4, done4, out4, z4, n4, c4, v4}, 64'h0);
    @(negedge clk);
    chk("inrst s1 done", 64'(done1), 64'h0);
    rst_n = 1'b1;
    prev1 = 32'h0;
    prev4 = 32'h0;
    run_op("post-rst add", 4'h0, 32'h2, 32'h3, 32'h5, 4'b0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
